// File: rtl/debounce_pkg.sv
// Shared constants and compile-time helpers for the multi-channel debouncer.
package debounce_pkg;

    localparam int DEF_CHANNELS      = 4;
    localparam int DEF_STABLE_CYCLES = 16;
    localparam int DEF_REPEAT_DELAY  = 1000000;
    localparam int DEF_REPEAT_PERIOD = 250000;

    // Bits needed to hold values 0 .. value-1 (value >= 2 gives width >= 1).
    function automatic int clog2_c(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return w;
    endfunction

    function automatic int max_c(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-flop synchroniser, symmetric stability filter,
// registered rise/fall pulses and, when DEBOUNCE_REPEAT_EN is defined, an
// auto-repeat pulse generator. Without the macro m_repeat is tied to 0.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic m_clock,
    input  logic m_reset_n,
    input  logic m_button,
    output logic m_state,
    output logic m_rise,
    output logic m_fall,
    output logic m_repeat
);

    localparam int CNT_W = clog2_c(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("debounce_channel: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             changing;
    logic             commit;

    // A new level is accepted on the cycle its count has already reached the last value.
    assign changing = (sync2 != m_state);
    assign commit   = changing && (cnt == CNT_LAST);

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge m_clock or negedge m_reset_n) begin
        if (!m_reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= m_button;
            sync2 <= sync1;
        end
    end

    // Stability filter: any return to the current level restarts the count.
    always_ff @(posedge m_clock or negedge m_reset_n) begin
        if (!m_reset_n) begin
            cnt     <= '0;
            m_state <= 1'b0;
            m_rise  <= 1'b0;
            m_fall  <= 1'b0;
        end else begin
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (!changing) begin
                cnt <= '0;
            end else if (commit) begin
                cnt     <= '0;
                m_state <= sync2;
                m_rise  <= sync2;
                m_fall  <= ~sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int RPT_W = clog2_c(max_c(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    // rpt_armed selects the interval: first REPEAT_DELAY, then REPEAT_PERIOD.
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_next;
    logic [RPT_W-1:0] rpt_target;
    logic             rpt_armed;

    assign rpt_next   = rpt_cnt + RPT_W'(1);
    assign rpt_target = rpt_armed ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);

    // Auto-repeat: cleared on every accepted edge, counts while the level is high.
    always_ff @(posedge m_clock or negedge m_reset_n) begin
        if (!m_reset_n) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
            m_repeat  <= 1'b0;
        end else begin
            m_repeat <= 1'b0;
            if (commit) begin
                rpt_cnt   <= '0;
                rpt_armed <= 1'b0;
            end else if (m_state) begin
                if (rpt_next == rpt_target) begin
                    rpt_cnt   <= '0;
                    rpt_armed <= 1'b1;
                    m_repeat  <= 1'b1;
                end else begin
                    rpt_cnt <= rpt_next;
                end
            end
        end
    end
`else
    assign m_repeat = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel button/switch debouncer: independent debounce_channel instances
// producing a clean level plus rise/fall pulses per channel.
// Build option: DEBOUNCE_REPEAT_EN adds per-channel auto-repeat on m_repeat.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS      = DEF_CHANNELS,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic                m_clock,
    input  logic                m_reset_n,
    input  logic [CHANNELS-1:0] m_button,
    output logic [CHANNELS-1:0] m_state,
    output logic [CHANNELS-1:0] m_rise,
    output logic [CHANNELS-1:0] m_fall,
    output logic [CHANNELS-1:0] m_repeat
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("debounce_multi: CHANNELS must be >= 1");
    end

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("debounce_multi: STABLE_CYCLES must be >= 2");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .m_clock   (m_clock),
            .m_reset_n (m_reset_n),
            .m_button  (m_button[i]),
            .m_state   (m_state[i]),
            .m_rise    (m_rise[i]),
            .m_fall    (m_fall[i]),
            .m_repeat  (m_repeat[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi (4 channels, 16-cycle filter, repeat 40/10).
// Driver pushes timestamped expected pulse events; a negedge monitor pops
// and compares whenever any rise/fall/repeat pulse is present.
module tb_debounce_multi;

    localparam int CH  = 4;
    localparam int LAT = 18;   // pin edge to m_state change, in clock edges
    localparam int W   = 48;   // {cycle[31:0], rise, fall, repeat, state}

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] button;
    logic [CH-1:0] state;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] rpt;

    logic [31:0]   cyc = 32'd0;
    logic [W-1:0]  exp_q[$];
    int            checks   = 0;
    int            failures = 0;

    debounce_multi #(
        .CHANNELS      (CH),
        .STABLE_CYCLES (16),
        .REPEAT_DELAY  (40),
        .REPEAT_PERIOD (10)
    ) dut (
        .m_clock   (clk),
        .m_reset_n (rst_n),
        .m_button  (button),
        .m_state   (state),
        .m_rise    (rise),
        .m_fall    (fall),
        .m_repeat  (rpt)
    );

    // Clock and cycle stamp
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Driver helpers
    function automatic logic [W-1:0] ev(input logic [31:0] t, input logic [3:0] r,
                                        input logic [3:0] f, input logic [3:0] p,
                                        input logic [3:0] s);
        return {t, r, f, p, s};
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [W-1:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] want;
        if (rst_n && ((rise | fall | rpt) != '0)) begin
            got = {cyc, rise, fall, rpt, state};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d rise=%b fall=%b rep=%b state=%b",
                         cyc, rise, fall, rpt, state);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL event got cyc=%0d r=%b f=%b p=%b s=%b want cyc=%0d r=%b f=%b p=%b s=%b",
                             got[47:16], got[15:12], got[11:8], got[7:4], got[3:0],
                             want[47:16], want[15:12], want[11:8], want[7:4], want[3:0]);
                end
            end
        end
    end

    // Directed sequence
    initial begin
        logic [31:0] r0;

        // 1: reset with all buttons held, then release
        rst_n  = 1'b0;
        button = 4'hF;
        wait_cyc(4);
        check_now("reset_outputs", {state, rise, fall, rpt}, 16'h0000);
        rst_n = 1'b1;
        push(ev(cyc + LAT, 4'hF, 4'h0, 4'h0, 4'hF));
        wait_cyc(LAT);
        check_now("release_state", {12'h000, state}, 16'h000F);
        button = 4'h0;
        push(ev(cyc + LAT, 4'h0, 4'hF, 4'h0, 4'h0));
        wait_cyc(LAT + 4);

        // 2: ch0 bounces 5 high / 3 low, then holds high
        for (int i = 0; i < 7; i++) begin
            button[0] = 1'b1;
            wait_cyc(5);
            button[0] = 1'b0;
            wait_cyc(3);
        end
        check_now("bounce_no_change", {12'h000, state}, 16'h0000);
        button[0] = 1'b1;
        push(ev(cyc + LAT, 4'b0001, 4'h0, 4'h0, 4'b0001));
        wait_cyc(LAT);
        button[0] = 1'b0;
        push(ev(cyc + LAT, 4'h0, 4'b0001, 4'h0, 4'h0));
        wait_cyc(LAT + 4);

        // 3: ch1 glitch of 15 cycles is rejected, 20-cycle drop is accepted
        button[1] = 1'b1;
        push(ev(cyc + LAT, 4'b0010, 4'h0, 4'h0, 4'b0010));
        wait_cyc(LAT);
        button[1] = 1'b0;
        wait_cyc(15);
        button[1] = 1'b1;
        wait_cyc(5);
        check_now("glitch15_hold", {12'h000, state}, 16'h0002);
        button[1] = 1'b0;
        push(ev(cyc + LAT, 4'h0, 4'b0010, 4'h0, 4'h0));
        wait_cyc(20);
        wait_cyc(4);

        // 4: ch2 and ch3 rise together
        button = 4'b1100;
        push(ev(cyc + LAT, 4'b1100, 4'h0, 4'h0, 4'b1100));
        wait_cyc(LAT);
        check_now("simul_state", {12'h000, state}, 16'h000C);
        button = 4'b0000;
        push(ev(cyc + LAT, 4'h0, 4'b1100, 4'h0, 4'h0));
        wait_cyc(LAT + 4);

        // 5: asynchronous reset while ch0 is mid-count (cnt=10), ch3 high
        button = 4'b1000;
        push(ev(cyc + LAT, 4'b1000, 4'h0, 4'h0, 4'b1000));
        wait_cyc(LAT);
        button = 4'b1001;
        wait_cyc(12);
        #2 rst_n = 1'b0;
        #1 check_now("async_reset", {state, rise, fall, rpt}, 16'h0000);
        wait_cyc(3);
        rst_n = 1'b1;
        push(ev(cyc + LAT, 4'b1001, 4'h0, 4'h0, 4'b1001));
        wait_cyc(LAT - 1);
        check_now("requalify_pending", {12'h000, state}, 16'h0000);
        wait_cyc(1);
        button = 4'b0000;
        push(ev(cyc + LAT, 4'h0, 4'b1001, 4'h0, 4'h0));
        wait_cyc(LAT + 4);

        // 6: ch0 held for 100 cycles after its rise
        button[0] = 1'b1;
        r0 = cyc + LAT;
        push(ev(r0, 4'b0001, 4'h0, 4'h0, 4'b0001));
`ifdef DEBOUNCE_REPEAT_EN
        for (int k = 0; k < 8; k++) begin
            push(ev(r0 + 32'd40 + 32'(10 * k), 4'h0, 4'h0, 4'b0001, 4'b0001));
        end
`endif
        wait_cyc(LAT + 100);
        button[0] = 1'b0;
        push(ev(cyc + LAT, 4'h0, 4'b0001, 4'h0, 4'h0));
        wait_cyc(LAT + 30);

        // Final report
        check_now("queue_drained", 16'(exp_q.size()), 16'h0000);
        check_now("final_state", {12'h000, state}, 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
